// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - E-stage bundle into, and M-stage bundle out of, the EX/MEM stage
interface ex_mem_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          EnM;
  logic          FlushM;
  logic          RegWriteE;
  logic          MemtoRegE;
  logic          MemWriteE;
  logic [2:0]    ALUControlE;
  logic          ALUSrcE;
  logic          RegDstE;
  logic [DW-1:0] RD1_E;
  logic [DW-1:0] RD2_E;
  logic [DW-1:0] SignImmE;
  logic [AW-1:0] RT_E;
  logic [AW-1:0] RD_E;
  logic [1:0]    ForwardAE;
  logic [1:0]    ForwardBE;
  logic [DW-1:0] ResultW;
  logic [AW-1:0] WriteRegE;
  logic          RegWriteM;
  logic          MemtoRegM;
  logic          MemWriteM;
  logic [DW-1:0] ALUOutM;
  logic [DW-1:0] WriteDataM;
  logic [AW-1:0] WriteRegM;
  logic          ZeroM;

  modport master (
    output EnM, FlushM, RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE, RegDstE,
           RD1_E, RD2_E, SignImmE, RT_E, RD_E, ForwardAE, ForwardBE, ResultW,
    input  WriteRegE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM, ZeroM
  );

  modport slave (
    input  EnM, FlushM, RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE, RegDstE,
           RD1_E, RD2_E, SignImmE, RT_E, RD_E, ForwardAE, ForwardBE, ResultW,
    output WriteRegE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM, ZeroM
  );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - MIPS execute stage: forwarding muxes, ALU, and EX/MEM pipeline register
module ex_mem_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic         clk,
  input  logic         clr_n,
  ex_mem_stage_if.slave bus
);

  logic [DW-1:0] src_a;
  logic [DW-1:0] fwd_b;
  logic [DW-1:0] src_b;
  logic [DW-1:0] alu_y;
  logic          alu_zero;
  logic [AW-1:0] write_reg_e;

  logic          reg_write_q, reg_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;
  logic          mem_write_q, mem_write_d;
  logic [DW-1:0] alu_out_q, alu_out_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic [AW-1:0] write_reg_q, write_reg_d;
  logic          zero_q, zero_d;

  // Select 10 feeds back the pre-edge ALUOutM so dependent instructions chain each cycle
  always_comb begin
    case (bus.ForwardAE)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = alu_out_q;
      default: src_a = bus.RD1_E;
    endcase
    case (bus.ForwardBE)
      2'b01:   fwd_b = bus.ResultW;
      2'b10:   fwd_b = alu_out_q;
      default: fwd_b = bus.RD2_E;
    endcase
  end

  assign src_b       = bus.ALUSrcE ? bus.SignImmE : fwd_b;
  assign write_reg_e = bus.RegDstE ? bus.RD_E : bus.RT_E;

  always_comb begin
    alu_y = '0;
    case (bus.ALUControlE)
      3'b010:  alu_y = src_a + src_b;
      3'b110:  alu_y = src_a - src_b;
      3'b000:  alu_y = src_a & src_b;
      3'b001:  alu_y = src_a | src_b;
      3'b100:  alu_y = src_a & ~src_b;
      3'b101:  alu_y = src_a | ~src_b;
      3'b111:  alu_y = {{(DW-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_y = '0;
    endcase
  end

  assign alu_zero = (alu_y == '0);

  // Flush beats enable; store data is the forwarded B operand, never the immediate
  always_comb begin
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_write_d  = mem_write_q;
    alu_out_d    = alu_out_q;
    write_data_d = write_data_q;
    write_reg_d  = write_reg_q;
    zero_d       = zero_q;
    if (bus.FlushM) begin
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 1'b0;
      alu_out_d    = '0;
      write_data_d = '0;
      write_reg_d  = '0;
      zero_d       = 1'b0;
    end else if (bus.EnM) begin
      reg_write_d  = bus.RegWriteE;
      mem_to_reg_d = bus.MemtoRegE;
      mem_write_d  = bus.MemWriteE;
      alu_out_d    = alu_y;
      write_data_d = fwd_b;
      write_reg_d  = write_reg_e;
      zero_d       = alu_zero;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_out_q    <= '0;
      write_data_q <= '0;
      write_reg_q  <= '0;
      zero_q       <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      alu_out_q    <= alu_out_d;
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
      zero_q       <= zero_d;
    end
  end

  assign bus.WriteRegE  = write_reg_e;
  assign bus.RegWriteM  = reg_write_q;
  assign bus.MemtoRegM  = mem_to_reg_q;
  assign bus.MemWriteM  = mem_write_q;
  assign bus.ALUOutM    = alu_out_q;
  assign bus.WriteDataM = write_data_q;
  assign bus.WriteRegM  = write_reg_q;
  assign bus.ZeroM      = zero_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage with directed vectors
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_stage_if #(.DW(32), .AW(5)) ifc ();

  ex_mem_stage #(.DW(32), .AW(5)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifc.slave)
  );

  typedef struct {
    string       name;
    logic        rw;
    logic        mtr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        z;
    logic [4:0]  wre;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   checks = 0;
  int   failures = 0;

  task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
    end
  endtask

  task automatic push(input string n, input logic rw, input logic mtr, input logic mw,
                      input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                      input logic z, input logic [4:0] wre);
    exp_t e;
    e.name = n; e.rw = rw; e.mtr = mtr; e.mw = mw; e.alu = alu;
    e.wd = wd; e.wr = wr; e.z = z; e.wre = wre;
    q.push_back(e);
  endtask

  task automatic drv(input logic [2:0] op, input logic src, input logic dst,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                     input logic [4:0] rt, input logic [4:0] rd,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic rw, input logic mtr, input logic mw);
    ifc.ALUControlE = op;  ifc.ALUSrcE = src;  ifc.RegDstE = dst;
    ifc.RD1_E = a;  ifc.RD2_E = b;  ifc.SignImmE = imm;
    ifc.RT_E = rt;  ifc.RD_E = rd;  ifc.ForwardAE = fa;  ifc.ForwardBE = fb;
    ifc.RegWriteE = rw;  ifc.MemtoRegE = mtr;  ifc.MemWriteE = mw;
  endtask

  // Monitor: one pop per rising edge, or on demand for between-edge (async reset) checks
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "RegWriteM",  {31'b0, ifc.RegWriteM}, {31'b0, e.rw});
        cmp(e.name, "MemtoRegM",  {31'b0, ifc.MemtoRegM}, {31'b0, e.mtr});
        cmp(e.name, "MemWriteM",  {31'b0, ifc.MemWriteM}, {31'b0, e.mw});
        cmp(e.name, "ALUOutM",    ifc.ALUOutM, e.alu);
        cmp(e.name, "WriteDataM", ifc.WriteDataM, e.wd);
        cmp(e.name, "WriteRegM",  {27'b0, ifc.WriteRegM}, {27'b0, e.wr});
        cmp(e.name, "ZeroM",      {31'b0, ifc.ZeroM}, {31'b0, e.z});
        cmp(e.name, "WriteRegE",  {27'b0, ifc.WriteRegE}, {27'b0, e.wre});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.EnM = 1'b1;  ifc.FlushM = 1'b0;  ifc.ResultW = 32'd0;
    drv(3'b010, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    #1;
    push("reset", 0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 5'd0);
    -> chk_ev;

    @(negedge clk);
    clr_n = 1'b1;
    drv(3'b010, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 5'd0, 5'd3, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push("add", 1, 0, 0, 32'd12, 32'd7, 5'd3, 0, 5'd3);

    @(negedge clk);
    ifc.ResultW = 32'd100;
    drv(3'b010, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 5'd3, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
    push("fwd", 1, 0, 0, 32'd112, 32'd100, 5'd3, 0, 5'd3);

    @(negedge clk);
    drv(3'b010, 1'b1, 1'b0, 32'd4, 32'd55, 32'hFFFF_FFFC, 5'd8, 5'd3, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push("imm", 1, 0, 0, 32'd0, 32'd55, 5'd8, 1, 5'd8);

    @(negedge clk);
    drv(3'b110, 1'b0, 1'b0, 32'd3, 32'd9, 32'hFFFF_FFFC, 5'd8, 5'd3, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push("sub", 1, 0, 0, 32'hFFFF_FFFA, 32'd9, 5'd8, 0, 5'd8);

    @(negedge clk);
    drv(3'b111, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd8, 5'd3, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push("slt_neg", 1, 0, 0, 32'd1, 32'd1, 5'd8, 0, 5'd8);

    @(negedge clk);
    drv(3'b111, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd8, 5'd3, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push("slt_pos", 1, 0, 0, 32'd0, 32'hFFFF_FFFF, 5'd8, 1, 5'd8);

    @(negedge clk);
    drv(3'b010, 1'b1, 1'b0, 32'h1000, 32'hDEAD, 32'h10, 5'd9, 5'd3, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1);
    push("store", 0, 0, 1, 32'h1010, 32'd100, 5'd9, 0, 5'd9);

    @(negedge clk);
    drv(3'b000, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'd0, 5'd9, 5'd12, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0);
    push("and", 1, 1, 0, 32'hF000, 32'hFF00, 5'd12, 0, 5'd12);

    @(negedge clk);
    drv(3'b001, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'd0, 5'd9, 5'd12, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push("or", 1, 0, 0, 32'hFFF0, 32'hFF00, 5'd12, 0, 5'd12);

    @(negedge clk);
    drv(3'b100, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'd0, 5'd9, 5'd12, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push("andn", 1, 0, 0, 32'h00F0, 32'hFF00, 5'd12, 0, 5'd12);

    @(negedge clk);
    drv(3'b101, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'd0, 5'd9, 5'd12, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push("orn", 1, 0, 0, 32'hFFFF_F0FF, 32'hFF00, 5'd12, 0, 5'd12);

    @(negedge clk);
    drv(3'b011, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'd0, 5'd9, 5'd12, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push("op011", 1, 0, 0, 32'd0, 32'hFF00, 5'd12, 1, 5'd12);

    @(negedge clk);
    drv(3'b010, 1'b1, 1'b1, 32'd77, 32'd0, 32'd5, 5'd9, 5'd12, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
    push("chain1", 1, 0, 0, 32'd5, 32'd0, 5'd12, 0, 5'd12);

    @(negedge clk);
    push("chain2", 1, 0, 0, 32'd10, 32'd0, 5'd12, 0, 5'd12);

    @(negedge clk);
    ifc.EnM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv(3'b110, 1'b0, 1'b1, 32'd50 + i, 32'd1, 32'd0, 5'd1, 5'd20 + 5'(i), 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
      push("hold", 1, 0, 0, 32'd10, 32'd0, 5'd12, 0, 5'd20 + 5'(i));
      @(negedge clk);
    end

    ifc.FlushM = 1'b1;
    push("flush_en0", 0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 5'd22);

    @(negedge clk);
    ifc.FlushM = 1'b0;  ifc.EnM = 1'b1;
    drv(3'b010, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 5'd0, 5'd3, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push("reload", 1, 0, 0, 32'd12, 32'd7, 5'd3, 0, 5'd3);

    @(negedge clk);
    ifc.FlushM = 1'b1;
    push("flush_en1", 0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 5'd3);

    @(negedge clk);
    ifc.FlushM = 1'b0;
    push("preload", 1, 0, 0, 32'd12, 32'd7, 5'd3, 0, 5'd3);

    @(negedge clk);
    #1;
    clr_n = 1'b0;
    #1;
    push("async_rst", 0, 0, 0, 32'd0, 32'd0, 5'd0, 0, 5'd3);
    -> chk_ev;

    @(negedge clk);
    clr_n = 1'b1;
    drv(3'b001, 1'b0, 1'b1, 32'd6, 32'd3, 32'd0, 5'd0, 5'd4, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    push("after_rst", 1, 0, 0, 32'd7, 32'd3, 5'd4, 0, 5'd4);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the 5-stage MIPS core.
- Consumes the E-stage control and data bundle produced by the decode/ID-EX stage.
- Applies hazard-unit forwarding, selects ALU operands and destination register, performs the ALU operation, and registers results into the M stage.
- Feeds ALUOutM back for forwarding and exports WriteRegE/WriteRegM for the hazard unit.

Parameters:
- DW, 32, datapath width
- AW, 5, register-address width

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  reset, asynchronous, active-low
- EnM  in  1  EX/MEM register load enable; 0 = hold
- FlushM  in  1  synchronous bubble insert
- RegWriteE, MemtoRegE, MemWriteE  in  1 each  E-stage control
- ALUControlE  in  3  ALU operation
- ALUSrcE  in  1  1 = SrcB is SignImmE
- RegDstE  in  1  1 = destination is RD_E, 0 = RT_E
- RD1_E, RD2_E  in  DW  register operands
- SignImmE  in  DW  sign-extended immediate
- RT_E, RD_E  in  AW  destination candidates
- ForwardAE, ForwardBE  in  2  forwarding selects from hazard unit
- ResultW  in  DW  writeback result
- WriteRegE  out  AW  combinational E-stage destination, for hazard unit
- RegWriteM, MemtoRegM, MemWriteM  out  1  registered control
- ALUOutM  out  DW  registered ALU result
- WriteDataM  out  DW  registered store data
- WriteRegM  out  AW  registered destination
- ZeroM  out  1  registered ALU zero flag

Behaviour:
- Reset (clr_n = 0, asynchronous): all registered outputs = 0 immediately and held until the first rising edge after deassertion.
- Forwarding (combinational):
  - SrcAE: 00 → RD1_E, 01 → ResultW, 10 → ALUOutM (current registered value), 11 → RD1_E.
  - Forwarded B (fwdB) uses ForwardBE with the same mapping on RD2_E.
- SrcBE = ALUSrcE ? SignImmE : fwdB.
- WriteRegE = RegDstE ? RD_E : RT_E.
- ALU, DW-bit, modulo 2^DW, no overflow trap:
  - 010 add; 110 sub; 000 and; 001 or.
  - 100 A & ~B; 101 A | ~B.
  - 111 slt, signed compare: result = {DW-1 zeros, (A <s B)}.
  - 011 → result 0.
- Zero = (ALU result == 0).
- Pipeline register update on a rising clk edge, priority order:
  1. FlushM = 1: all registered outputs = 0. A bubble with RegWrite = MemWrite = 0; the flush overrides EnM.
  2. Else EnM = 1: load RegWriteE, MemtoRegE, MemWriteE, ALU result, fwdB (not SrcBE) into WriteDataM, WriteRegE, Zero.
  3. Else hold all outputs.
- Latency: exactly one cycle from E inputs to M outputs.
- Self-forward: ForwardAE/ForwardBE = 10 uses the pre-edge ALUOutM. Back-to-back dependent instructions therefore chain correctly cycle by cycle.
- Reset mid-operation: in-flight M contents are discarded. No partial state is retained.
- No combinational path from EnM/FlushM to any output.

Test Plan:
- Reset, then add: clr_n low, then release. Check all M outputs = 0. Apply RD1_E = 5, RD2_E = 7, ALUControlE = 010, ALUSrcE = 0, RegDstE = 1, RD_E = 3, RegWriteE = 1. Next edge → ALUOutM = 12, WriteRegM = 3, RegWriteM = 1, ZeroM = 0.
- Immediate and sub: ALUSrcE = 1, SignImmE = 0xFFFFFFFC, RD1_E = 4, ALUControlE = 010 → ALUOutM = 0, ZeroM = 1. Then RD1_E = 3, RD2_E = 9, ALUControlE = 110, ALUSrcE = 0 → ALUOutM = 0xFFFFFFFA.
- slt signed: RD1_E = 0xFFFFFFFF, RD2_E = 1, ALUControlE = 111 → ALUOutM = 1. Swap the operands → ALUOutM = 0.
- Forwarding:
  - ALUOutM holding 12, ResultW = 100, ForwardAE = 10, ForwardBE = 01, add → ALUOutM = 112 on the next edge.
  - Store with MemWriteE = 1, ALUSrcE = 1, ForwardBE = 01 → WriteDataM = 100, not SignImmE.
- Hold and flush:
  - EnM = 0 for 3 cycles while inputs change → M outputs stay unchanged.
  - FlushM = 1 with EnM = 0 → all outputs 0 next edge.
  - FlushM = 1 together with EnM = 1 → also all outputs 0.
- Async reset mid-stream: assert clr_n low between edges while RegWriteM = 1 → outputs 0 before the next edge. Release → resumes normal loading.
